// File: rtl/ldr_pkg.sv
// Shared types and constants for the imem byte-stream program loader.
package ldr_pkg;

  typedef enum logic [2:0] {IDLE, LEN, DATA, WR, CSUM, DONE, ERR} ldr_state_t;

  localparam logic [7:0] HDR_DEFAULT    = 8'hA5;
  localparam int         CMD_W_DEFAULT  = 16;
  localparam int         BYTES_PER_WORD = CMD_W_DEFAULT / 8;

  function automatic int bytes_per_word(input int cmd_w);
    return cmd_w / 8;
  endfunction

endpackage

// File: rtl/ldr_pack.sv
// Byte-to-word assembler: shifts bytes in MSB first and flags the byte that completes a word.
module ldr_pack
  import ldr_pkg::*;
#(
  parameter int CMD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic [7:0]       in_byte,
  output logic [CMD_W-1:0] word_next,
  output logic             last
);

  localparam int BPW   = bytes_per_word(CMD_W);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CMD_W-1:0] word_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CMD_W+7:0] shifted;

  // Word as it will look once the current byte is shifted in.
  assign shifted   = {word_reg, in_byte};
  assign word_next = shifted[CMD_W-1:0];
  assign last      = shift_en && (cnt_reg == CNT_W'(BPW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else if (clear) begin
      word_reg <= '0;
      cnt_reg  <= '0;
    end else if (shift_en) begin
      word_reg <= word_next;
      cnt_reg  <= last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes words into imem and releases the core on a good checksum.
module imem_loader
  import ldr_pkg::*;
#(
  parameter int         CMD_W  = 16,
  parameter int         ADDR_W = 8,
  parameter logic [7:0] HDR    = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              iw_we,
  output logic [ADDR_W-1:0] iw_addr,
  output logic [CMD_W-1:0]  iw_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  ldr_state_t        state_reg, state_next;
  logic [7:0]        n_reg, widx_reg, sum_reg;
  logic              done_reg, err_reg, cpu_rst_reg;
  logic [ADDR_W-1:0] iw_addr_reg;
  logic [CMD_W-1:0]  iw_data_reg;
  logic              accept, start, len_take, shift_en, ck_take, ck_ok, pack_last;
  logic [CMD_W-1:0]  word_next;

  ldr_pack #(.CMD_W(CMD_W)) u_pack (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .clear     (start),
    .in_byte   (in_data),
    .word_next (word_next),
    .last      (pack_last)
  );

  assign in_ready = (state_reg != WR);
  assign accept   = in_valid && in_ready;
  assign ck_ok    = (in_data == sum_reg);
  assign iw_we    = (state_reg == WR);
  assign iw_addr  = iw_addr_reg;
  assign iw_data  = iw_data_reg;
  // A new header drops the core back into reset in the very cycle it is offered.
  assign cpu_rst  = cpu_rst_reg && !start;
  assign done     = done_reg;
  assign err      = err_reg;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    len_take   = 1'b0;
    shift_en   = 1'b0;
    ck_take    = 1'b0;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (accept && in_data == HDR) begin
          start      = 1'b1;
          state_next = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          len_take   = 1'b1;
          state_next = (in_data == 8'd0) ? CSUM : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          shift_en = 1'b1;
          if (pack_last) state_next = WR;
        end
      end
      WR: begin
        state_next = (({1'b0, widx_reg} + 9'd1) == {1'b0, n_reg}) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) begin
          ck_take    = 1'b1;
          state_next = ck_ok ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      n_reg       <= '0;
      widx_reg    <= '0;
      sum_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cpu_rst_reg <= 1'b0;
      iw_addr_reg <= '0;
      iw_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        n_reg       <= '0;
        widx_reg    <= '0;
        sum_reg     <= '0;
        done_reg    <= 1'b0;
        err_reg     <= 1'b0;
        cpu_rst_reg <= 1'b0;
      end
      if (len_take) n_reg <= in_data;
      if (shift_en) begin
        sum_reg <= sum_reg + in_data;
        // Capture address and word now so they are stable through the WR cycle.
        if (pack_last) begin
          iw_addr_reg <= ADDR_W'(widx_reg);
          iw_data_reg <= word_next;
        end
      end
      if (state_reg == WR) widx_reg <= widx_reg + 8'd1;
      if (ck_take) begin
        done_reg    <= ck_ok;
        err_reg     <= !ck_ok;
        cpu_rst_reg <= ck_ok;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames, checksum errors, stalls and mid-frame reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, iw_we, cpu_rst, done, err;
  logic [7:0]  iw_addr;
  logic [15:0] iw_data;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [7:0]  log_a[$];
  logic [15:0] log_d[$];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .iw_we    (iw_we),
    .iw_addr  (iw_addr),
    .iw_data  (iw_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iw_we === 1'b1) begin
      log_a.push_back(iw_addr);
      log_d.push_back(iw_data);
      $display("write addr=%h data=%h", iw_addr, iw_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    $display("byte %h accepted=%0d", b, ok);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_iw_we"},    32'(iw_we),    32'd0);
    chk({tag, "_iw_addr"},  32'(iw_addr),  32'd0);
    chk({tag, "_iw_data"},  32'(iw_data),  32'd0);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // Frame 1: good checksum.
    send(8'hA5); send(8'h02);
    send(8'h12);
    chk("f1_no_we_midword", 32'(iw_we), 32'd0);
    send(8'h34);
    chk("f1_we0", 32'(iw_we), 32'd1);
    chk("f1_addr0", 32'(iw_addr), 32'h00);
    chk("f1_data0", 32'(iw_data), 32'h1234);
    chk("f1_rdy_wr", 32'(in_ready), 32'd0);
    send(8'hAB); send(8'hCD);
    chk("f1_cpu_rst_before_ck", 32'(cpu_rst), 32'd0);
    send(8'hBE);
    chk("f1_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_err", 32'(err), 32'd0);
    chk("f1_nwr", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      chk("f1_a1", 32'(log_a[1]), 32'h01);
      chk("f1_d1", 32'(log_d[1]), 32'hABCD);
    end
    log_a.delete(); log_d.delete();

    // New header from DONE: core goes back into reset the same cycle.
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    chk("f2_cpu_rst_same_cycle", 32'(cpu_rst), 32'd0);
    send(8'hA5);
    chk("f2_done_clr", 32'(done), 32'd0);
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'hBF);
    chk("f2_err", 32'(err), 32'd1);
    chk("f2_done", 32'(done), 32'd0);
    chk("f2_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("f2_nwr", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) chk("f2_a0", 32'(log_a[0]), 32'h00);
    log_a.delete(); log_d.delete();

    // Junk bytes, then an empty frame.
    send(8'h00); send(8'hFF);
    chk("f3_err_held", 32'(err), 32'd1);
    send(8'hA5); send(8'h00); send(8'h00);
    chk("f3_nwr", 32'(log_a.size()), 32'd0);
    chk("f3_done", 32'(done), 32'd1);
    chk("f3_err", 32'(err), 32'd0);
    chk("f3_cpu_rst", 32'(cpu_rst), 32'd1);

    // N=3 with valid held: 0102 0304 0506, CK = 0x15.
    stalls = 0;
    send(8'hA5); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
    send(8'h15);
    chk("f4_stalls", 32'(stalls), 32'd3);
    chk("f4_nwr", 32'(log_a.size()), 32'd3);
    if (log_a.size() == 3) begin
      chk("f4_a0", 32'(log_a[0]), 32'h00); chk("f4_d0", 32'(log_d[0]), 32'h0102);
      chk("f4_a1", 32'(log_a[1]), 32'h01); chk("f4_d1", 32'(log_d[1]), 32'h0304);
      chk("f4_a2", 32'(log_a[2]), 32'h02); chk("f4_d2", 32'(log_d[2]), 32'h0506);
    end
    chk("f4_done", 32'(done), 32'd1);
    log_a.delete(); log_d.delete();

    // Reset mid-frame, then a clean frame: 8899, CK = 0x21.
    send(8'hA5); send(8'h01); send(8'h77);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(8'hA5); send(8'h01); send(8'h88); send(8'h99); send(8'h21);
    chk("f5_nwr", 32'(log_a.size()), 32'd1);
    if (log_a.size() == 1) begin
      chk("f5_a0", 32'(log_a[0]), 32'h00);
      chk("f5_d0", 32'(log_d[0]), 32'h8899);
    end
    chk("f5_done", 32'(done), 32'd1);
    chk("f5_cpu_rst", 32'(cpu_rst), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
